// File: rtl/proc_pkg.sv
// proc_pkg: shared loader state encoding and image framing constants
package proc_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;
    localparam int HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle watchdog; expired_o fires on the cycle the count would reach TIMEOUT
module loader_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        count_d = clr_i ? '0 : en_i ? count_q + 1'b1 : count_q;
        expired_o = (TIMEOUT > 0) && en_i && !clr_i && (count_q == CW'(TIMEOUT - 1));
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed little-endian byte stream into words for
// instruction memory, holding the core in reset until the image is complete
module imem_boot_loader
    import proc_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int ADDR_W = 7,
    parameter int TIMEOUT = 1_000_000,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int NW = 8 * HDR_BYTES;
    state_t state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0] bc_q, bc_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [NW-1:0] n_q, n_d, n_next;
    logic accept, expired, last_word, last_byte, start_ok, tmr_en;
    assign accept = rx_valid_i & rx_ready_o;
    assign n_next = {rx_data_i, n_q[NW-1:8]};
    assign last_word = NW'(idx_q) + NW'(1) == n_q;
    assign last_byte = bc_q == 2'(BYTES_PER_WORD - 1);
    assign start_ok = start_i & (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign tmr_en = state_q inside {S_LEN1, S_DATA};
    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept | !tmr_en),
        .en_i     (tmr_en),
        .expired_o(expired)
    );
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state_q <= BOOT_ON_RESET ? S_LEN0 : S_IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: state_d = start_i ? S_LEN0 : state_q;
            S_LEN0: state_d = accept ? S_LEN1 : S_LEN0;
            S_LEN1:
                if (accept) state_d = n_next == '0 ? S_DONE : n_next > NW'(DEPTH) ? S_ERROR : S_DATA;
                else if (expired) state_d = S_ERROR;
            S_DATA:
                if (accept && last_byte) state_d = S_WRITE;
                else if (expired) state_d = S_ERROR;
            S_WRITE: state_d = last_word ? S_DONE : S_DATA;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        rx_ready_o = state_q inside {S_LEN0, S_LEN1, S_DATA};
        we_o = state_q == S_WRITE;
        busy_o = rx_ready_o | we_o;
        cpu_reset_o = busy_o | (state_q == S_ERROR);
        done_o = state_q == S_DONE;
        err_o = state_q == S_ERROR;
        waddr_o = idx_q[ADDR_W-1:0];
        wdata_o = word_q;
    end
    // Bytes shift in from the top so the first byte of a word ends up in [7:0]
    always_comb begin
        word_d = (state_q == S_DATA && accept) ? {rx_data_i, word_q[31:8]} : word_q;
        bc_d = start_ok ? 2'd0 : (state_q == S_DATA && accept) ? bc_q + 2'd1 : bc_q;
        idx_d = start_ok ? '0 : (state_q == S_WRITE && !last_word) ? idx_q + 1'b1 : idx_q;
        n_d = (accept && state_q inside {S_LEN0, S_LEN1}) ? n_next : n_q;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            word_q <= '0;
            bc_q <= '0;
            idx_q <= '0;
            n_q <= '0;
        end else begin
            word_q <= word_d;
            bc_q <= bc_d;
            idx_q <= idx_d;
            n_q <= n_d;
        end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scenarios for the boot loader with hand-computed expectations
module tb_imem_boot_loader;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ready, we, cpu_reset, busy, done, err;
    logic [6:0] waddr;
    logic [31:0] wdata;
    int errors = 0, checks = 0;
    logic [6:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(128), .ADDR_W(7), .TIMEOUT(16), .BOOT_ON_RESET(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .cpu_reset_o(cpu_reset), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always @(negedge clk) if (we) begin wa_q.push_back(waddr); wd_q.push_back(wdata); end

    // Called at a negedge; returns at the negedge right after the byte was accepted, rx_valid still high
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1; rx_data = b;
        while (!rx_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin checks++; errors++; $display("FAIL send_byte: rx_ready stuck low for byte %h", b); end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start;
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({we, waddr, wdata, done, err} !== 41'd0) begin errors++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h done=%b err=%b, want all 0", we, waddr, wdata, done, err); end
        checks++;
        if ({cpu_reset, busy, rx_ready} !== 3'b111) begin errors++;
            $display("FAIL reset_boot: cpu_reset=%b busy=%b rx_ready=%b, want 111", cpu_reset, busy, rx_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load4;
        logic [31:0] img [4];
        img = '{32'hE5909C04, 32'hE5809C00, 32'hE5809C18, 32'hEAFFFFFB};
        wa_q.delete(); wd_q.delete();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_word(img[i]);
            if (i == 3) rx_valid = 1'b0;
            checks++;
            if (we !== 1'b1 || waddr !== 7'(i) || wdata !== img[i]) begin errors++;
                $display("FAIL load4_word%0d: we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h", i, we, waddr, wdata, i, img[i]); end
        end
        checks++;
        if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load4_hold_in_write: cpu_reset=%b want 1", cpu_reset); end
        @(negedge clk);
        checks++;
        if ({done, err, cpu_reset, busy, we} !== 5'b10000) begin errors++;
            $display("FAIL load4_done: done=%b err=%b cpu_reset=%b busy=%b we=%b, want 10000", done, err, cpu_reset, busy, we); end
        checks++;
        if (wa_q.size() != 4) begin errors++; $display("FAIL load4_we_count: got %0d pulses want 4", wa_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[i] !== 7'(i) || wd_q[i] !== img[i]) begin errors++;
                $display("FAIL load4_log%0d: addr=%0d data=%h want addr=%0d data=%h", i, wa_q[i], wd_q[i], i, img[i]); end
        end
    endtask

    task automatic test_zero_len;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++;
        if ({done, busy, cpu_reset, rx_ready} !== 4'b0111) begin errors++;
            $display("FAIL zero_restart: done=%b busy=%b cpu_reset=%b rx_ready=%b, want 0111", done, busy, cpu_reset, rx_ready); end
        send_byte(8'h00); send_byte(8'h00); rx_valid = 1'b0;
        checks++;
        if ({done, err, cpu_reset, busy} !== 4'b1000) begin errors++;
            $display("FAIL zero_done: done=%b err=%b cpu_reset=%b busy=%b, want 1000", done, err, cpu_reset, busy); end
        @(negedge clk);
        checks++;
        if (wa_q.size() != 0) begin errors++; $display("FAIL zero_no_we: got %0d pulses want 0", wa_q.size()); end
    endtask

    task automatic test_too_long;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h81); send_byte(8'h00); rx_valid = 1'b0;
        checks++;
        if ({err, done, cpu_reset, rx_ready, busy, we} !== 6'b101000) begin errors++;
            $display("FAIL n129_error: err=%b done=%b cpu_reset=%b rx_ready=%b busy=%b we=%b, want 101000", err, done, cpu_reset, rx_ready, busy, we); end
        pulse_start();
        send_byte(8'h80); send_byte(8'h00); rx_valid = 1'b0;
        checks++;
        if ({err, busy, rx_ready} !== 3'b011) begin errors++;
            $display("FAIL n128_legal: err=%b busy=%b rx_ready=%b, want 011", err, busy, rx_ready); end
        repeat (16) @(negedge clk);
        checks++;
        if (err !== 1'b1 || wa_q.size() != 0) begin errors++;
            $display("FAIL n128_idle_timeout: err=%b pulses=%0d, want err=1 pulses=0", err, wa_q.size()); end
    endtask

    task automatic test_timeout;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hAABBCCDD);
        send_byte(8'h11); rx_valid = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: err=%b busy=%b after 15 idle cycles, want err=0 busy=1", err, busy); end
        @(negedge clk);
        checks++;
        if ({err, cpu_reset, busy, done} !== 4'b1100) begin errors++;
            $display("FAIL timeout_fire: err=%b cpu_reset=%b busy=%b done=%b after 16 idle cycles, want 1100", err, cpu_reset, busy, done); end
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 7'd0 || wd_q[0] !== 32'hAABBCCDD) begin errors++;
            $display("FAIL timeout_partial: pulses=%0d, want one at addr 0 data aabbccdd", wa_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] img [3];
        img = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i == 1 && j == 2) start = 1'b1;
                send_byte(img[i][8*j +: 8]);
                start = 1'b0;
            end
            if (i == 2) rx_valid = 1'b0;
            checks++;
            if (we !== 1'b1 || rx_ready !== 1'b0 || waddr !== 7'(i) || wdata !== img[i]) begin errors++;
                $display("FAIL b2b_word%0d: we=%b rx_ready=%b addr=%0d data=%h, want we=1 rx_ready=0 addr=%0d data=%h", i, we, rx_ready, waddr, wdata, i, img[i]); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL b2b_done: done=%b cpu_reset=%b, want 1 0", done, cpu_reset); end
        checks++;
        if (wa_q.size() != 3) begin errors++; $display("FAIL b2b_we_count: got %0d pulses want 3", wa_q.size()); end
    endtask

    task automatic test_reset_midload;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h03); send_byte(8'h00);
        send_word(32'hCAFEF00D);
        send_byte(8'hA1); send_byte(8'hA2); rx_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({we, wdata, busy, cpu_reset, done, err} !== {1'b0, 32'd0, 4'b1100}) begin errors++;
            $display("FAIL midreset_state: we=%b data=%h busy=%b cpu_reset=%b done=%b err=%b, want 0 0 1 1 0 0", we, wdata, busy, cpu_reset, done, err); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wa_q.size() != 1) begin errors++; $display("FAIL midreset_we_count: got %0d pulses want 1", wa_q.size()); end
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h12345678); rx_valid = 1'b0;
        checks++;
        if (we !== 1'b1 || waddr !== 7'd0 || wdata !== 32'h12345678) begin errors++;
            $display("FAIL reload_we: we=%b addr=%0d data=%h, want 1 0 12345678", we, waddr, wdata); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || wa_q.size() != 1) begin errors++;
            $display("FAIL reload_done: done=%b cpu_reset=%b pulses=%0d, want 1 0 1", done, cpu_reset, wa_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load4();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_back_to_back();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
